// File: rtl/conv_buf_pkg.sv
// Shared types and sizing helpers for the strided KxK window generator.
package conv_buf_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} conv_state_t;

  function automatic int out_dim(int img, int k, int s, int p);
    return (img + 2 * p - k) / s + 1;
  endfunction

  // Width of a counter that must hold 0..n
  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_line_store.sv
// Line memory for the window generator: one (K-1)-pixel column history per padded column.
module conv_line_store #(
  parameter int DEPTH = 34,
  parameter int WIDTH = 48,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_stream.sv
// Raster pixel stream in, zero-padded strided KxK windows out, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// RUN   | walking padded raster, consuming interior pixels
// DRAIN | walking trailing pad positions, no input consumed
module conv_window_stream
  import conv_buf_pkg::*;
#(
  parameter int KER_SIZE = 3,
  parameter int BITWIDTH = 8,
  parameter int NFMAPS   = 3,
  parameter int STRIDE   = 1,
  parameter int PAD      = 1,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NFMAPS*BITWIDTH-1:0]               in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NFMAPS*KER_SIZE*KER_SIZE*BITWIDTH-1:0] q,
  output logic                                     out_last,
  output logic                                     frame_done
);

  localparam int K    = KER_SIZE;
  localparam int DW   = BITWIDTH;
  localparam int PIXW = NFMAPS * BITWIDTH;
  localparam int PW   = IMG_W + 2 * PAD;
  localparam int PH   = IMG_H + 2 * PAD;
  localparam int XW   = cnt_w(PW);
  localparam int YW   = cnt_w(PH);
  localparam int SW   = cnt_w(STRIDE);
  localparam int LAW  = $clog2(PW);
  localparam int OW   = out_dim(IMG_W, K, STRIDE, PAD);
  localparam int OH   = out_dim(IMG_H, K, STRIDE, PAD);

  localparam logic [XW-1:0] X_LAST  = XW'(PW - 1);
  localparam logic [XW-1:0] X_FILL  = XW'(K - 1);
  localparam logic [XW-1:0] X_LO    = XW'(PAD);
  localparam logic [XW-1:0] X_SPAN  = XW'(IMG_W);
  localparam logic [XW-1:0] X_HI    = XW'(PAD + IMG_W - 1);
  localparam logic [XW-1:0] X_WLAST = XW'((OW - 1) * STRIDE + K - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(PH - 1);
  localparam logic [YW-1:0] Y_FILL  = YW'(K - 1);
  localparam logic [YW-1:0] Y_LO    = YW'(PAD);
  localparam logic [YW-1:0] Y_SPAN  = YW'(IMG_H);
  localparam logic [YW-1:0] Y_HI    = YW'(PAD + IMG_H - 1);
  localparam logic [YW-1:0] Y_WLAST = YW'((OH - 1) * STRIDE + K - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(STRIDE - 1);

  conv_state_t state, state_nxt;
  logic [XW-1:0] vx, vx_off;
  logic [YW-1:0] vy, vy_off;
  logic [SW-1:0] xph, yph;
  logic interior, can_move, adv, emit, x_end, y_end, last_int;
  logic [PIXW-1:0] px;
  logic [(K-1)*PIXW-1:0] mem_rd, mem_wr;
  logic [PIXW-1:0] win     [K][K];
  logic [PIXW-1:0] win_nxt [K][K];
  logic [NFMAPS*K*K*DW-1:0] q_nxt;

  // Offset compare: positions left of the pad wrap to large values and fail the span test
  assign vx_off   = vx - X_LO;
  assign vy_off   = vy - Y_LO;
  assign interior = (vx_off < X_SPAN) && (vy_off < Y_SPAN);
  assign can_move = !out_valid || out_ready;
  assign adv      = can_move && (!interior || in_valid) && (state != IDLE);
  assign in_ready = interior && can_move && (state == RUN) && !rst;
  assign px       = interior ? in_data : '0;
  assign x_end    = (vx == X_LAST);
  assign y_end    = (vy == Y_LAST);
  assign last_int = (vx == X_HI) && (vy == Y_HI);
  assign emit     = adv && (vx >= X_FILL) && (vy >= Y_FILL) && (xph == '0) && (yph == '0);

  conv_line_store #(
    .DEPTH (PW),
    .WIDTH ((K - 1) * PIXW),
    .AW    (LAW)
  ) u_line (
    .clk   (clk),
    .we    (adv),
    .addr  (vx[LAW-1:0]),
    .wdata (mem_wr),
    .rdata (mem_rd)
  );

  generate
    if (K == 2) begin : g_k2
      assign mem_wr = px;
    end else begin : g_kn
      assign mem_wr = {mem_rd[(K-2)*PIXW-1:0], px};
    end
  endgenerate

  // Oldest stored row feeds the top of the incoming column
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int x = 0; x < K - 1; x++) win_nxt[r][x] = win[r][x+1];
    end
    for (int r = 0; r < K - 1; r++) win_nxt[r][K-1] = mem_rd[(K-2-r)*PIXW +: PIXW];
    win_nxt[K-1][K-1] = px;
  end

  always_comb begin
    q_nxt = '0;
    for (int c = 0; c < NFMAPS; c++)
      for (int r = 0; r < K; r++)
        for (int x = 0; x < K; x++)
          q_nxt[((c*K+r)*K+x)*DW +: DW] = win_nxt[r][x][c*DW +: DW];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (adv && last_int) state_nxt = (x_end && y_end) ? IDLE : DRAIN;
      DRAIN:   if (adv && x_end && y_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (adv) win <= win_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vx         <= '0;
      vy         <= '0;
      xph        <= '0;
      yph        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      q          <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state != IDLE) && (state_nxt == IDLE);
      if (adv) begin
        if (x_end) begin
          vx  <= '0;
          xph <= '0;
          vy  <= y_end ? '0 : vy + YW'(1);
          if (y_end) yph <= '0;
          else if (vy >= Y_FILL) yph <= (yph == S_LAST) ? '0 : yph + SW'(1);
        end else begin
          vx <= vx + XW'(1);
          if (vx >= X_FILL) xph <= (xph == S_LAST) ? '0 : xph + SW'(1);
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        q         <= q_nxt;
        out_last  <= (vx == X_WLAST) && (vy == Y_WLAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_stream.sv
// Bench for conv_window_stream: four configurations behind one shared driver, checked against a direct window model.
module tb_conv_window_stream;

  localparam int QW = 600;

  typedef struct {
    int cfg;
    int widx;
    int row;
    int v0;
    int v1;
    int v2;
  } hv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [23:0] in_data;
  logic        out_ready;
  int          sel;

  logic [3:0]   rst_v, iv_v, ir_v, ov_v, ol_v, fd_v;
  logic [215:0] q0, q1;
  logic [599:0] q2;
  logic [95:0]  q3;
  logic         in_ready_m, out_valid_m, out_last_m, frame_done_m;
  logic [QW-1:0] q_m;

  int K, S, P, W, H, OW, OH;
  logic [23:0]   pix [2][36];
  logic [QW-1:0] cap[$];
  logic          cap_last[$];
  logic [QW-1:0] cap_a[$];
  logic [QW-1:0] cap_b[$];
  int n_checks = 0;
  int n_fail   = 0;
  hv_t tbl [12];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = rst || (sel != i);
      iv_v[i]  = in_valid && (sel == i);
    end
  end

  always_comb begin
    in_ready_m   = ir_v[sel[1:0]];
    out_valid_m  = ov_v[sel[1:0]];
    out_last_m   = ol_v[sel[1:0]];
    frame_done_m = fd_v[sel[1:0]];
    case (sel)
      0:       q_m = QW'(q0);
      1:       q_m = QW'(q1);
      2:       q_m = q2;
      default: q_m = QW'(q3);
    endcase
  end

  conv_window_stream #(.KER_SIZE(3), .BITWIDTH(8), .NFMAPS(3), .STRIDE(1), .PAD(1), .IMG_W(4), .IMG_H(4)) u_c0 (
    .clk(clk), .rst(rst_v[0]), .in_valid(iv_v[0]), .in_ready(ir_v[0]), .in_data(in_data),
    .out_valid(ov_v[0]), .out_ready(out_ready), .q(q0), .out_last(ol_v[0]), .frame_done(fd_v[0]));

  conv_window_stream #(.KER_SIZE(3), .BITWIDTH(8), .NFMAPS(3), .STRIDE(2), .PAD(1), .IMG_W(4), .IMG_H(4)) u_c1 (
    .clk(clk), .rst(rst_v[1]), .in_valid(iv_v[1]), .in_ready(ir_v[1]), .in_data(in_data),
    .out_valid(ov_v[1]), .out_ready(out_ready), .q(q1), .out_last(ol_v[1]), .frame_done(fd_v[1]));

  conv_window_stream #(.KER_SIZE(5), .BITWIDTH(8), .NFMAPS(3), .STRIDE(1), .PAD(2), .IMG_W(6), .IMG_H(6)) u_c2 (
    .clk(clk), .rst(rst_v[2]), .in_valid(iv_v[2]), .in_ready(ir_v[2]), .in_data(in_data),
    .out_valid(ov_v[2]), .out_ready(out_ready), .q(q2), .out_last(ol_v[2]), .frame_done(fd_v[2]));

  conv_window_stream #(.KER_SIZE(2), .BITWIDTH(8), .NFMAPS(3), .STRIDE(1), .PAD(0), .IMG_W(6), .IMG_H(6)) u_c3 (
    .clk(clk), .rst(rst_v[3]), .in_valid(iv_v[3]), .in_ready(ir_v[3]), .in_data(in_data),
    .out_valid(ov_v[3]), .out_ready(out_ready), .q(q3), .out_last(ol_v[3]), .frame_done(fd_v[3]));

  task automatic chk(input string nm, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [QW-1:0] gold(int f, int ox, int oy);
    logic [QW-1:0] g;
    int iy, ix;
    g = '0;
    for (int r = 0; r < K; r++) begin
      for (int x = 0; x < K; x++) begin
        iy = oy * S + r - P;
        ix = ox * S + x - P;
        if (iy >= 0 && iy < H && ix >= 0 && ix < W)
          for (int c = 0; c < 3; c++) g[((c*K+r)*K+x)*8 +: 8] = pix[f][iy*W+ix][c*8 +: 8];
      end
    end
    return g;
  endfunction

  task automatic set_cfg(input int c);
    case (c)
      0:       begin K = 3; S = 1; P = 1; W = 4; H = 4; end
      1:       begin K = 3; S = 2; P = 1; W = 4; H = 4; end
      2:       begin K = 5; S = 1; P = 2; W = 6; H = 6; end
      default: begin K = 2; S = 1; P = 0; W = 6; H = 6; end
    endcase
    OW = (W + 2 * P - K) / S + 1;
    OH = (H + 2 * P - K) / S + 1;
    @(negedge clk);
    sel = c; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_random(input int f);
    for (int i = 0; i < 36; i++) pix[f][i] = 24'($urandom);
  endtask

  task automatic run_frames(input int nfr, input int pct, input int stall_at);
    int idx, done_cnt, stall_cnt, npx, nwin, j;
    bit stalled, timed_out;
    logic [QW-1:0] hold_q;
    npx = W * H; nwin = OW * OH;
    idx = 0; done_cnt = 0; stall_cnt = 0; stalled = 0; timed_out = 1; hold_q = '0;
    cap.delete(); cap_last.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (stall_at >= 0 && !stalled && stall_cnt == 0 && idx >= stall_at && out_valid_m) begin
        stall_cnt = 5;
        hold_q = q_m;
      end
      out_ready = (stall_cnt == 0);
      in_valid  = (idx < nfr * npx) && ($urandom_range(99) < pct);
      in_data   = in_valid ? pix[idx / npx][idx % npx] : 24'($urandom);
      #1;
      if (stall_cnt > 0) begin
        chk_int("stall_in_ready", int'(in_ready_m), 0);
        if (stall_cnt < 5) begin
          chk_int("stall_out_valid", int'(out_valid_m), 1);
          chk("stall_q_hold", q_m, hold_q);
        end
        stall_cnt--;
        if (stall_cnt == 0) stalled = 1;
      end
      if (in_valid && in_ready_m) idx++;
      if (out_valid_m && out_ready) begin
        cap.push_back(q_m);
        cap_last.push_back(out_last_m);
      end
      if (frame_done_m) done_cnt++;
      if (done_cnt == nfr && idx == nfr * npx && (!out_valid_m || out_ready)) begin
        timed_out = 0;
        break;
      end
    end
    if (timed_out) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: got %0d pixels %0d frames expected %0d pixels %0d frames", idx, done_cnt, nfr * npx, nfr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (stall_at >= 0) chk_int("stall_seen", int'(stalled), 1);
    chk_int("frame_done_count", done_cnt, nfr);
    chk_int("window_count", cap.size(), nfr * nwin);
    for (int i = 0; i < cap.size() && i < nfr * nwin; i++) begin
      j = i % nwin;
      chk($sformatf("window_%0d", i), cap[i], gold(i / nwin, j % OW, j / OW));
      chk_int($sformatf("out_last_%0d", i), int'(cap_last[i]), (j == nwin - 1) ? 1 : 0);
    end
  endtask

  function automatic logic [23:0] row_of(logic [QW-1:0] v, int r);
    return {v[(r*3+0)*8 +: 8], v[(r*3+1)*8 +: 8], v[(r*3+2)*8 +: 8]};
  endfunction

  initial begin
    int acc;
    logic [QW-1:0] w;
    logic [23:0] exp_row;

    tbl[0]  = '{0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 0,  1, 0, 1, 2};
    tbl[2]  = '{0, 0,  2, 0, 5, 6};
    tbl[3]  = '{0, 15, 0, 11, 12, 0};
    tbl[4]  = '{0, 15, 1, 15, 16, 0};
    tbl[5]  = '{0, 15, 2, 0, 0, 0};
    tbl[6]  = '{1, 0,  2, 0, 5, 6};
    tbl[7]  = '{1, 1,  0, 0, 0, 0};
    tbl[8]  = '{1, 1,  1, 2, 3, 4};
    tbl[9]  = '{1, 1,  2, 6, 7, 8};
    tbl[10] = '{1, 3,  0, 6, 7, 8};
    tbl[11] = '{1, 3,  2, 14, 15, 16};

    rst = 1'b1; sel = 0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

    // reset state
    set_cfg(0);
    #1;
    chk_int("reset_out_valid", int'(out_valid_m), 0);
    chk_int("reset_in_ready", int'(in_ready_m), 0);
    chk_int("reset_out_last", int'(out_last_m), 0);
    chk_int("reset_frame_done", int'(frame_done_m), 0);
    chk("reset_q", q_m, '0);

    // pixels 1..16 on every channel, stride 1 then stride 2
    for (int i = 0; i < 16; i++) pix[0][i] = {3{8'(i + 1)}};
    run_frames(1, 100, -1);
    cap_a = cap;
    set_cfg(1);
    run_frames(1, 100, -1);
    cap_b = cap;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].cfg == 0) begin
        if (tbl[i].widx < cap_a.size()) w = cap_a[tbl[i].widx];
        else w = '1;
      end else begin
        if (tbl[i].widx < cap_b.size()) w = cap_b[tbl[i].widx];
        else w = '1;
      end
      exp_row = {8'(tbl[i].v0), 8'(tbl[i].v1), 8'(tbl[i].v2)};
      chk($sformatf("table_cfg%0d_w%0d_r%0d", tbl[i].cfg, tbl[i].widx, tbl[i].row),
          QW'(row_of(w, tbl[i].row)), QW'(exp_row));
    end

    // consumer stall mid-frame
    set_cfg(0);
    fill_random(0);
    run_frames(1, 100, 6);

    // reset after 7 accepted pixels, then a clean frame
    set_cfg(0);
    fill_random(0);
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 7; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = pix[0][acc]; out_ready = 1'b1;
      #1;
      if (in_ready_m) acc++;
    end
    chk_int("pre_reset_accepted", acc, 7);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_int("midrst_out_valid", int'(out_valid_m), 0);
    chk_int("midrst_in_ready", int'(in_ready_m), 0);
    chk_int("midrst_out_last", int'(out_last_m), 0);
    chk_int("midrst_frame_done", int'(frame_done_m), 0);
    chk("midrst_q", q_m, '0);
    fill_random(0);
    run_frames(1, 100, -1);

    // two back-to-back frames with sparse input
    set_cfg(0);
    fill_random(0);
    fill_random(1);
    run_frames(2, 50, -1);

    // K5 P2 and K2 P0 on 6x6 random data
    set_cfg(2);
    fill_random(0);
    run_frames(1, 100, -1);
    set_cfg(3);
    fill_random(0);
    run_frames(1, 70, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
